piso_reg: RTL and testbench

Parallel-in serial-out serializer that sits directly upstream of SIPO_reg. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per strobe. Each bit is presented on serial_data_o qualified by a one-cycle wr_en_o pulse, so that SIPO_reg rebuilds the word on the far side. The block provides optional inter-bit gap cycles and an optional parity bit.

---
 rtl/piso_reg.sv | 210 +++++++++++++++++++++
 tb/tb_piso_reg.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_reg.sv
// piso_reg: parallel-in serial-out serializer feeding SIPO_reg, one bit per wr_en_o strobe.
// Latency: first strobe in the cycle after acceptance; word period INPUT_BW+1 cycles at GAP_CYCLES=0.
// Backpressure: ready_o low while a word is in flight (load_i ignored); ready again in DONE/IDLE.
//
// Optional feature macro: PISO_PARITY_EN -- appends one even-parity strobe after the data bits.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   reset_i        synchronous active-high reset, aborts any word in flight
//   din_bus_i      parallel word, sampled only on the acceptance edge
//   load_i         word valid, accepted when load_i && ready_o
//   ready_o        high when a new word can be accepted
//   serial_data_o  current serial bit (to SIPO_reg serial_data_i)
//   wr_en_o        one-cycle bit strobe (to SIPO_reg wr_en_i)
//   done_o         one-cycle pulse after the last strobe of a word
module piso_reg #(
    parameter int INPUT_BW   = 8,
    parameter int GAP_CYCLES = 0,
    parameter int LSB_FIRST  = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [INPUT_BW-1:0] din_bus_i,
    input  logic                load_i,
    output logic                ready_o,
    output logic                serial_data_o,
    output logic                wr_en_o,
    output logic                done_o
);

    localparam int CNT_W = $clog2(INPUT_BW + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(INPUT_BW);
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    // State names the cycle being presented on the outputs:
    // SHIFT = a data strobe is on the wire, GAP = idle between strobes.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
`ifdef PISO_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]          state, state_nxt;
    logic [INPUT_BW-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]          gap_cnt, gap_cnt_nxt;
    logic                ready_nxt, serial_nxt, wr_en_nxt, done_nxt;
`ifdef PISO_PARITY_EN
    logic                parity, parity_nxt;
`endif

    logic                accept;
    logic                head_bit, next_bit;
    logic [INPUT_BW-1:0] din_rest, shreg_rest;

    assign accept = load_i && ready_o;

    // The bit about to go out always sits at the transmit end of the register;
    // the first bit is taken straight from din_bus_i so it can strobe next cycle.
    always_comb begin
        if (LSB_FIRST != 0) begin
            head_bit   = din_bus_i[0];
            din_rest   = din_bus_i >> 1;
            next_bit   = shreg[0];
            shreg_rest = shreg >> 1;
        end else begin
            head_bit   = din_bus_i[INPUT_BW-1];
            din_rest   = din_bus_i << 1;
            next_bit   = shreg[INPUT_BW-1];
            shreg_rest = shreg << 1;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        serial_nxt  = serial_data_o;
        wr_en_nxt   = 1'b0;
        done_nxt    = 1'b0;
        ready_nxt   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_nxt  = parity;
`endif
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt   = SHIFT;
                    shreg_nxt   = din_rest;
                    serial_nxt  = head_bit;
                    wr_en_nxt   = 1'b1;
                    bit_cnt_nxt = CNT_W'(1);
`ifdef PISO_PARITY_EN
                    parity_nxt  = ^din_bus_i;
`endif
                end else begin
                    state_nxt   = IDLE;
                    ready_nxt   = 1'b1;
                    serial_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt != LAST_BIT) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = 8'd0;
                    end else begin
                        serial_nxt  = next_bit;
                        shreg_nxt   = shreg_rest;
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        wr_en_nxt   = 1'b1;
                    end
                end else begin
`ifdef PISO_PARITY_EN
                    // The parity strobe is spaced like any other bit.
                    if (GAP_CYCLES > 0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt   = PARITY;
                        serial_nxt  = parity;
                        wr_en_nxt   = 1'b1;
                    end
`else
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    ready_nxt   = 1'b1;
                    serial_nxt  = 1'b0;
                    bit_cnt_nxt = '0;
`endif
                end
            end
            GAP: begin
                // serial_data_o holds the previous bit through the gap.
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = 8'd0;
                    if (bit_cnt != LAST_BIT) begin
                        state_nxt   = SHIFT;
                        serial_nxt  = next_bit;
                        shreg_nxt   = shreg_rest;
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        wr_en_nxt   = 1'b1;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_nxt   = PARITY;
                        serial_nxt  = parity;
                        wr_en_nxt   = 1'b1;
`else
                        state_nxt   = DONE;
                        done_nxt    = 1'b1;
                        ready_nxt   = 1'b1;
                        serial_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
`endif
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_nxt   = DONE;
                done_nxt    = 1'b1;
                ready_nxt   = 1'b1;
                serial_nxt  = 1'b0;
                bit_cnt_nxt = '0;
            end
`endif
            default: begin
                state_nxt   = IDLE;
                ready_nxt   = 1'b1;
                serial_nxt  = 1'b0;
                bit_cnt_nxt = '0;
                gap_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= 8'd0;
            ready_o       <= 1'b1;
            serial_data_o <= 1'b0;
            wr_en_o       <= 1'b0;
            done_o        <= 1'b0;
`ifdef PISO_PARITY_EN
            parity        <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            shreg         <= shreg_nxt;
            bit_cnt       <= bit_cnt_nxt;
            gap_cnt       <= gap_cnt_nxt;
            ready_o       <= ready_nxt;
            serial_data_o <= serial_nxt;
            wr_en_o       <= wr_en_nxt;
            done_o        <= done_nxt;
`ifdef PISO_PARITY_EN
            parity        <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_piso_reg.sv
// tb_piso_reg: two serializer instances (MSB-first no gap, LSB-first gap 2) driven
// cycle by cycle from a stimulus schedule; every output is compared per cycle
// against a trace built from the word, bit order, gap and parity rules.
module tb_piso_reg;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int MAXC = 64;

    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic [1:0]   rst, load, ready, ser, wr, done;
    logic [W-1:0] din [2];

    piso_reg #(.INPUT_BW(W), .GAP_CYCLES(0), .LSB_FIRST(0)) dut0 (
        .clk_i(clk_tb), .reset_i(rst[0]), .din_bus_i(din[0]), .load_i(load[0]),
        .ready_o(ready[0]), .serial_data_o(ser[0]), .wr_en_o(wr[0]), .done_o(done[0]));

    piso_reg #(.INPUT_BW(W), .GAP_CYCLES(2), .LSB_FIRST(1)) dut1 (
        .clk_i(clk_tb), .reset_i(rst[1]), .din_bus_i(din[1]), .load_i(load[1]),
        .ready_o(ready[1]), .serial_data_o(ser[1]), .wr_en_o(wr[1]), .done_o(done[1]));

    int n_vec = 0;
    int n_err = 0;

    bit       ld_s [MAXC];
    bit       rst_s [MAXC];
    logic [W-1:0] din_s [MAXC];
    logic     o_wr [MAXC], o_ser [MAXC], o_done [MAXC], o_rdy [MAXC];
    bit       e_wr [MAXC], e_ser [MAXC], e_done [MAXC], e_rdy [MAXC];
    string    sig_name [4] = '{"wr_en", "serial", "done", "ready"};

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit lsb_of(input int d);
        return d == 1;
    endfunction

    // Cycles from the acceptance edge to the done pulse.
    function automatic int word_len(input int d);
        return 1 + (NB - 1) * (gap_of(d) + 1) + 1;
    endfunction

    function automatic void clear_sched();
        for (int k = 0; k < MAXC; k++) begin
            ld_s[k]  = 1'b0;
            rst_s[k] = 1'b0;
            din_s[k] = W'($urandom);
            e_wr[k]  = 1'b0;
            e_ser[k] = 1'b0;
            e_done[k] = 1'b0;
            e_rdy[k] = 1'b1;
        end
    endfunction

    // Expected outputs for word w accepted at the end of cycle a; abort_at >= 0
    // truncates the word at that cycle (reset seen on the previous edge).
    function automatic void model_word(input int d, input int a, input logic [W-1:0] w,
                                       input int abort_at);
        int g;
        int k;
        g = gap_of(d);
        for (int i = 0; i < NB; i++) begin
            bit b;
            if (i >= W)          b = ($countones(w) % 2) == 1;
            else if (lsb_of(d))  b = w[i];
            else                 b = w[W-1-i];
            for (int j = 0; j <= g; j++) begin
                if (i == NB - 1 && j > 0) break;
                k = a + 1 + i * (g + 1) + j;
                if (abort_at >= 0 && k >= abort_at) return;
                e_wr[k]  = (j == 0);
                e_ser[k] = b;
                e_rdy[k] = 1'b0;
            end
        end
        k = a + word_len(d);
        if (!(abort_at >= 0 && k >= abort_at)) e_done[k] = 1'b1;
    endfunction

    function automatic logic [MAXC-1:0] trace(input int sel, input bit want, input int n);
        logic [MAXC-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            case (sel)
                0:       v[k] = want ? e_wr[k]   : o_wr[k];
                1:       v[k] = want ? e_ser[k]  : o_ser[k];
                2:       v[k] = want ? e_done[k] : o_done[k];
                default: v[k] = want ? e_rdy[k]  : o_rdy[k];
            endcase
        end
        return v;
    endfunction

    // Rebuild the word from the first W observed strobes, as the far-side SIPO would.
    function automatic logic [W-1:0] decode(input int d, input int n);
        logic [W-1:0] v;
        int cnt;
        v = '0;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (o_wr[k] === 1'b1 && cnt < W) begin
                if (lsb_of(d)) v[cnt] = o_ser[k];
                else           v[W-1-cnt] = o_ser[k];
                cnt++;
            end
        end
        return v;
    endfunction

    // Sample cycle k at the falling edge, then drive that cycle's inputs.
    task automatic run(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_tb);
            o_wr[k]   = wr[d];
            o_ser[k]  = ser[d];
            o_done[k] = done[d];
            o_rdy[k]  = ready[d];
            load[d]   = ld_s[k];
            rst[d]    = rst_s[k];
            din[d]    = din_s[k];
        end
    endtask

    task automatic test_reset();
        rst  = 2'b11;
        load = 2'b11;
        din[0] = W'($urandom);
        din[1] = W'($urandom);
        repeat (2) @(negedge clk_tb);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (ready[d] !== 1'b1) begin
                n_err++; $display("FAIL reset_ready dut%0d: got %b want 1", d, ready[d]);
            end
            n_vec++;
            if (wr[d] !== 1'b0) begin
                n_err++; $display("FAIL reset_wr_en dut%0d: got %b want 0", d, wr[d]);
            end
            n_vec++;
            if (ser[d] !== 1'b0) begin
                n_err++; $display("FAIL reset_serial dut%0d: got %b want 0", d, ser[d]);
            end
            n_vec++;
            if (done[d] !== 1'b0) begin
                n_err++; $display("FAIL reset_done dut%0d: got %b want 0", d, done[d]);
            end
        end
        rst  = 2'b00;
        load = 2'b00;
    endtask

    task automatic test_single(input string name, input int d, input logic [W-1:0] w);
        int n;
        clear_sched();
        ld_s[0]  = 1'b1;
        din_s[0] = w;
        model_word(d, 0, w, -1);
        n = word_len(d) + 2;
        run(d, n);
        for (int s = 0; s < 4; s++) begin
            n_vec++;
            if (trace(s, 1'b0, n) !== trace(s, 1'b1, n)) begin
                n_err++;
                $display("FAIL %s dut%0d %s trace: got %h want %h", name, d, sig_name[s],
                         trace(s, 1'b0, n), trace(s, 1'b1, n));
            end
        end
        n_vec++;
        if (decode(d, n) !== w) begin
            n_err++; $display("FAIL %s dut%0d decoded word: got %h want %h", name, d, decode(d, n), w);
        end
    endtask

    task automatic test_msb_first();
        test_single("msb_a5", 0, 8'hA5);
    endtask

    task automatic test_lsb_gap();
        test_single("lsb_gap_0f", 1, 8'h0F);
    endtask

    task automatic test_edge_patterns();
        logic [W-1:0] pats [4] = '{8'h00, 8'hFF, 8'h07, 8'hA5};
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 4; p++)
                test_single("edge", d, pats[p]);
    endtask

    task automatic test_back_to_back();
        int n;
        int len;
        for (int d = 0; d < 2; d++) begin
            clear_sched();
            len = word_len(d);
            ld_s[0]  = 1'b1;
            din_s[0] = 8'h3C;
            for (int k = 1; k < len; k++) begin
                ld_s[k]  = 1'b1;
                din_s[k] = 8'hFF;
            end
            ld_s[len]  = 1'b1;
            din_s[len] = 8'hC3;
            model_word(d, 0, 8'h3C, -1);
            model_word(d, len, 8'hC3, -1);
            n = 2 * len + 2;
            run(d, n);
            for (int s = 0; s < 4; s++) begin
                n_vec++;
                if (trace(s, 1'b0, n) !== trace(s, 1'b1, n)) begin
                    n_err++;
                    $display("FAIL back_to_back dut%0d %s trace: got %h want %h", d, sig_name[s],
                             trace(s, 1'b0, n), trace(s, 1'b1, n));
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int n;
        int s3;
        for (int d = 0; d < 2; d++) begin
            clear_sched();
            s3 = 1 + 2 * (gap_of(d) + 1);
            ld_s[0]   = 1'b1;
            din_s[0]  = 8'hA5;
            rst_s[s3] = 1'b1;
            ld_s[s3]  = 1'b1;
            ld_s[s3 + 2]  = 1'b1;
            din_s[s3 + 2] = 8'h5A;
            model_word(d, 0, 8'hA5, s3 + 1);
            model_word(d, s3 + 2, 8'h5A, -1);
            n = s3 + 2 + word_len(d) + 2;
            run(d, n);
            for (int s = 0; s < 4; s++) begin
                n_vec++;
                if (trace(s, 1'b0, n) !== trace(s, 1'b1, n)) begin
                    n_err++;
                    $display("FAIL reset_mid_word dut%0d %s trace: got %h want %h", d, sig_name[s],
                             trace(s, 1'b0, n), trace(s, 1'b1, n));
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        int d;
        int len;
        logic [W-1:0] w;
        for (int it = 0; it < 20; it++) begin
            clear_sched();
            d   = int'($urandom_range(1, 0));
            w   = W'($urandom);
            len = word_len(d);
            ld_s[0]  = 1'b1;
            din_s[0] = w;
            // Loads while busy must be ignored.
            for (int k = 1; k < len; k++) ld_s[k] = bit'($urandom_range(1, 0));
            model_word(d, 0, w, -1);
            n = len + 2;
            run(d, n);
            for (int s = 0; s < 4; s++) begin
                n_vec++;
                if (trace(s, 1'b0, n) !== trace(s, 1'b1, n)) begin
                    n_err++;
                    $display("FAIL random it%0d dut%0d word %h %s trace: got %h want %h", it, d, w,
                             sig_name[s], trace(s, 1'b0, n), trace(s, 1'b1, n));
                end
            end
            n_vec++;
            if (decode(d, n) !== w) begin
                n_err++; $display("FAIL random it%0d dut%0d decoded word: got %h want %h", it, d, decode(d, n), w);
            end
        end
    endtask

    initial begin
        rst    = 2'b11;
        load   = 2'b00;
        din[0] = '0;
        din[1] = '0;
        test_reset();
        test_msb_first();
        test_lsb_gap();
        test_back_to_back();
        test_reset_mid_word();
        test_edge_patterns();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
